// File: rtl/mag_stats_pkg.sv
// Shared types and default tuning for the magnitude statistics block.
// Holds the alarm FSM encoding, default window/threshold constants and a small max helper.
package mag_stats_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ALARM = 1'b1
   } alarm_state_t;

   localparam int         DEF_WIN_LOG2 = 3;
   localparam logic [7:0] DEF_THR_HI   = 8'd100;
   localparam logic [7:0] DEF_THR_LO   = 8'd60;

   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mag_window_avg.sv
// Block-average of 2^WIN_LOG2 accepted samples; avg_out/avg_valid register one edge after completion.
// No backpressure: every in_valid sample is taken; win_done/win_avg expose the completing sum combinationally.
module mag_window_avg
   import mag_stats_pkg::*;
#(
   parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_mag,
   input  logic       clr,
   output logic       win_done,
   output logic [7:0] win_avg,
   output logic       avg_valid,
   output logic [7:0] avg_out
);

   localparam int ACC_W = 8 + WIN_LOG2;

   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [WIN_LOG2-1:0] cnt;

   // Worst case sum is 2^WIN_LOG2 * 255, which always fits in ACC_W bits.
   assign acc_sum  = acc + {{WIN_LOG2{1'b0}}, in_mag};
   assign win_done = in_valid && !clr && (cnt == {WIN_LOG2{1'b1}});
   assign win_avg  = acc_sum[ACC_W-1:WIN_LOG2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         avg_out   <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (win_done) begin
            avg_out   <= win_avg;
            avg_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else if (in_valid) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mag_stats.sv
// Windowed average, peak hold and hysteresis alarm over an 8-bit magnitude stream; outputs update one edge after input.
// Always accepts in_valid; define MAG_STATS_PEAK_DECAY_EN to halve the held peak at each window completion.
module mag_stats
   import mag_stats_pkg::*;
#(
   parameter int         WIN_LOG2 = DEF_WIN_LOG2,
   parameter logic [7:0] THR_HI   = DEF_THR_HI,
   parameter logic [7:0] THR_LO   = DEF_THR_LO
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_mag,
   input  logic       clr,
   output logic       avg_valid,
   output logic [7:0] avg_out,
   output logic [7:0] peak_out,
   output logic       alarm
);

   logic         win_done;
   logic [7:0]   win_avg;
   alarm_state_t state;

   mag_window_avg #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_win (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_mag    (in_mag),
      .clr       (clr),
      .win_done  (win_done),
      .win_avg   (win_avg),
      .avg_valid (avg_valid),
      .avg_out   (avg_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_out <= '0;
      end else if (clr) begin
         peak_out <= '0;
      end else if (in_valid) begin
`ifdef MAG_STATS_PEAK_DECAY_EN
         if (win_done)
            peak_out <= max8(in_mag, peak_out >> 1);
         else
            peak_out <= max8(in_mag, peak_out);
`else
         peak_out <= max8(in_mag, peak_out);
`endif
      end
   end

   // FSM only moves on completion edges, judged on the average being registered that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         alarm <= 1'b0;
      end else if (clr) begin
         state <= IDLE;
         alarm <= 1'b0;
      end else if (win_done) begin
         case (state)
            IDLE: begin
               if (win_avg >= THR_HI) begin
                  state <= ALARM;
                  alarm <= 1'b1;
               end
            end
            ALARM: begin
               if (win_avg < THR_LO) begin
                  state <= IDLE;
                  alarm <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mag_stats.sv
// Directed bench for mag_stats with WIN_LOG2=3, THR_HI=100, THR_LO=60.
module tb_mag_stats;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_mag;
   logic       clr;
   logic       avg_valid;
   logic [7:0] avg_out;
   logic [7:0] peak_out;
   logic       alarm;

   int n_cmp = 0;
   int n_err = 0;

   mag_stats #(
      .WIN_LOG2 (3),
      .THR_HI   (8'd100),
      .THR_LO   (8'd60)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_mag    (in_mag),
      .clr       (clr),
      .avg_valid (avg_valid),
      .avg_out   (avg_out),
      .peak_out  (peak_out),
      .alarm     (alarm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [7:0] m);
      in_valid = 1'b1;
      in_mag   = m;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic samples(input int n, input logic [7:0] m);
      for (int i = 0; i < n; i++) sample(m);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_mag   = 8'd0;
      clr      = 1'b0;

      // Reset values while held
      repeat (3) tick();
      chk("rst_avg_valid", avg_valid, 0);
      chk("rst_avg_out", avg_out, 0);
      chk("rst_peak", peak_out, 0);
      chk("rst_alarm", alarm, 0);
      rst_n = 1'b1;
      tick();

      // Basic window of 50s
      samples(7, 8'd50);
      chk("basic_no_early_valid", avg_valid, 0);
      sample(8'd50);
      chk("basic_valid", avg_valid, 1);
      chk("basic_avg", avg_out, 50);
      chk("basic_alarm", alarm, 0);
      tick();
      chk("basic_valid_pulse_end", avg_valid, 0);
      chk("basic_avg_held", avg_out, 50);

      // Hysteresis 120 -> 80 -> 40
      samples(8, 8'd120);
      chk("hyst120_avg", avg_out, 120);
      chk("hyst120_alarm", alarm, 1);
      samples(8, 8'd80);
      chk("hyst80_avg", avg_out, 80);
      chk("hyst80_alarm", alarm, 1);
      samples(8, 8'd40);
      chk("hyst40_avg", avg_out, 40);
      chk("hyst40_alarm", alarm, 0);

      // Peak, then clear with a coincident sample
      samples(8, 8'd120);
      chk("pre_clr_alarm", alarm, 1);
      sample(8'd10);
      sample(8'd200);
      sample(8'd30);
      chk("peak_200", peak_out, 200);
      chk("peak_alarm_held", alarm, 1);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_mag   = 8'd255;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("clr_peak", peak_out, 0);
      chk("clr_alarm", alarm, 0);
      chk("clr_avg_kept", avg_out, 120);
      chk("clr_avg_valid", avg_valid, 0);
      samples(7, 8'd16);
      chk("clr_7_no_valid", avg_valid, 0);
      chk("clr_7_avg_kept", avg_out, 120);
      chk("clr_7_peak", peak_out, 16);
      sample(8'd16);
      chk("clr_8_valid", avg_valid, 1);
      chk("clr_8_avg", avg_out, 16);

      // Full scale with idle gaps
      for (int i = 0; i < 8; i++) begin
         sample(8'd255);
         if (i < 7) begin
            tick();
            tick();
            chk("gap_no_valid", avg_valid, 0);
         end
      end
      chk("full_valid", avg_valid, 1);
      chk("full_avg", avg_out, 255);
      chk("full_alarm", alarm, 1);
      chk("full_peak", peak_out, 255);

      // Asynchronous reset mid-window
      samples(5, 8'd200);
      #2 rst_n = 1'b0;
      #1;
      chk("async_avg_out", avg_out, 0);
      chk("async_peak", peak_out, 0);
      chk("async_alarm", alarm, 0);
      chk("async_avg_valid", avg_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      samples(7, 8'd20);
      chk("post_rst_7_no_valid", avg_valid, 0);
      sample(8'd20);
      chk("post_rst_valid", avg_valid, 1);
      chk("post_rst_avg", avg_out, 20);
      chk("post_rst_alarm", alarm, 0);

      // Peak across a completion: 200 closes a window, then a window of 10s
      samples(7, 8'd10);
      sample(8'd200);
      chk("decay_peak_set", peak_out, 200);
      chk("decay_avg_a", avg_out, 33);
      samples(8, 8'd10);
      chk("decay_avg_b", avg_out, 10);
`ifdef MAG_STATS_PEAK_DECAY_EN
      chk("decay_peak_after", peak_out, 100);
`else
      chk("hold_peak_after", peak_out, 200);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
